// File: rtl/polar_arbiter.sv
// rtl/polar_arbiter.sv - round-robin front end and in-order result router for a shared polar pipeline
// Define POLAR_ARB_STATS_EN to build the issued-sample counter behind stat_issued.
module polar_arbiter #(
    parameter  int WIDTH = 32,
    parameter  int NREQ  = 4,
    parameter  int LAT   = 17,
    parameter  int DEPTH = 32,
    localparam int IDW   = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_vld,
    output logic [NREQ-1:0]       req_rdy,
    input  logic [NREQ*WIDTH-1:0] req_x,
    input  logic [NREQ*WIDTH-1:0] req_y,
    output logic                  cp_vld,
    output logic [WIDTH-1:0]      cp_x,
    output logic [WIDTH-1:0]      cp_y,
    input  logic                  cp_res_vld,
    input  logic [WIDTH-1:0]      cp_mag,
    input  logic [31:0]           cp_phase,
    output logic                  res_vld,
    input  logic                  res_rdy,
    output logic [IDW-1:0]        res_id,
    output logic [WIDTH-1:0]      res_mag,
    output logic [31:0]           res_phase,
    output logic                  err,
    output logic [31:0]           stat_issued
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   gnt_idx;
    logic [IDW:0]     cand;
    logic             gnt_found;
    logic [WIDTH-1:0] sel_x;
    logic [WIDTH-1:0] sel_y;
    logic             credit_ok;
    logic             issue;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count;
    logic [IDW-1:0]   cp_id;
    logic [LAT-1:0]   tag_vld;
    logic [IDW-1:0]   tag_id [LAT];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [IDW-1:0]   mem_id    [DEPTH];
    logic [WIDTH-1:0] mem_mag   [DEPTH];
    logic [31:0]      mem_phase [DEPTH];

    // Scan from the RR pointer upward, wrapping at NREQ (which need not be a power of two).
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = {1'b0, rr_ptr} + (IDW+1)'(i);
            if (cand >= (IDW+1)'(NREQ)) begin
                cand = cand - (IDW+1)'(NREQ);
            end
            if (!gnt_found && req_vld[cand[IDW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IDW-1:0];
            end
        end
    end

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        req_rdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_idx == IDW'(i)) begin
                sel_x      = req_x[i*WIDTH +: WIDTH];
                sel_y      = req_y[i*WIDTH +: WIDTH];
                req_rdy[i] = credit_ok && gnt_found;
            end
        end
    end

    // Credits cover everything issued but not yet popped, so a push always finds a free slot.
    assign credit_ok = count < CW'(DEPTH);
    assign issue     = |(req_vld & req_rdy);
    assign res_vld   = wr_ptr != rd_ptr;
    assign pop       = res_vld && res_rdy;
    assign push      = cp_res_vld && tag_vld[LAT-1];
    assign res_id    = mem_id[rd_ptr[AW-1:0]];
    assign res_mag   = mem_mag[rd_ptr[AW-1:0]];
    assign res_phase = mem_phase[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr  <= '0;
            cp_vld  <= 1'b0;
            cp_x    <= '0;
            cp_y    <= '0;
            cp_id   <= '0;
            tag_vld <= '0;
            count   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            err     <= 1'b0;
        end else begin
            cp_vld  <= issue;
            tag_vld <= {tag_vld[LAT-2:0], cp_vld};
            if (issue) begin
                rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + IDW'(1);
                cp_x   <= sel_x;
                cp_y   <= sel_y;
                cp_id  <= gnt_idx;
            end
            if (issue && !pop) begin
                count <= count + CW'(1);
            end else if (!issue && pop) begin
                count <= count - CW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
            if (cp_res_vld != tag_vld[LAT-1]) begin
                err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        tag_id[0] <= cp_id;
        for (int i = 1; i < LAT; i++) begin
            tag_id[i] <= tag_id[i-1];
        end
        if (push) begin
            mem_id[wr_ptr[AW-1:0]]    <= tag_id[LAT-1];
            mem_mag[wr_ptr[AW-1:0]]   <= cp_mag;
            mem_phase[wr_ptr[AW-1:0]] <= cp_phase;
        end
    end

`ifdef POLAR_ARB_STATS_EN
    logic [31:0] stat_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_cnt <= '0;
        end else if (issue) begin
            stat_cnt <= stat_cnt + 32'd1;
        end
    end

    assign stat_issued = stat_cnt;
`else
    assign stat_issued = 32'd0;
`endif

endmodule

// File: tb/tb_polar_arbiter.sv
// tb/tb_polar_arbiter.sv - directed and randomized checks of polar_arbiter against a queue-based reference
module tb_polar_arbiter;
    localparam int WIDTH = 32;
    localparam int NREQ  = 4;
    localparam int LAT   = 17;
    localparam int DEPTH = 32;
    localparam int IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req_vld = '0;
    logic [NREQ-1:0]       req_rdy;
    logic [NREQ*WIDTH-1:0] req_x = '0;
    logic [NREQ*WIDTH-1:0] req_y = '0;
    logic                  cp_vld;
    logic [WIDTH-1:0]      cp_x;
    logic [WIDTH-1:0]      cp_y;
    logic                  cp_res_vld;
    logic [WIDTH-1:0]      cp_mag;
    logic [31:0]           cp_phase;
    logic                  res_vld;
    logic                  res_rdy = 1'b1;
    logic [IDW-1:0]        res_id;
    logic [WIDTH-1:0]      res_mag;
    logic [31:0]           res_phase;
    logic                  err;
    logic [31:0]           stat_issued;
    logic                  inject = 1'b0;

    polar_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .req_vld(req_vld), .req_rdy(req_rdy), .req_x(req_x), .req_y(req_y),
        .cp_vld(cp_vld), .cp_x(cp_x), .cp_y(cp_y),
        .cp_res_vld(cp_res_vld), .cp_mag(cp_mag), .cp_phase(cp_phase),
        .res_vld(res_vld), .res_rdy(res_rdy), .res_id(res_id),
        .res_mag(res_mag), .res_phase(res_phase),
        .err(err), .stat_issued(stat_issued)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mag_f(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] ax;
        logic [31:0] ay;
        ax = x[31] ? -x : x;
        ay = y[31] ? -y : y;
        return ax + ay;
    endfunction

    function automatic logic [31:0] phase_f(input logic [31:0] x, input logic [31:0] y);
        return {x[15:0], y[15:0]} ^ 32'h5a5a_3c3c;
    endfunction

    // Fixed-latency pipeline stand-in, reset on the same rst as the arbiter.
    logic        p_vld [LAT];
    logic [31:0] p_x   [LAT];
    logic [31:0] p_y   [LAT];

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LAT; i++) p_vld[i] <= 1'b0;
        end else begin
            p_vld[0] <= cp_vld;
            p_x[0]   <= cp_x;
            p_y[0]   <= cp_y;
            for (int i = 1; i < LAT; i++) begin
                p_vld[i] <= p_vld[i-1];
                p_x[i]   <= p_x[i-1];
                p_y[i]   <= p_y[i-1];
            end
        end
    end

    assign cp_res_vld = p_vld[LAT-1] | inject;
    assign cp_mag     = mag_f(p_x[LAT-1], p_y[LAT-1]);
    assign cp_phase   = phase_f(p_x[LAT-1], p_y[LAT-1]);

    typedef struct {
        int          id;
        logic [31:0] mag;
        logic [31:0] ph;
        int          t;
    } ent_t;

    ent_t        q[$];
    int          ptr = 0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          issued = 0;
    int          dut_xfers = 0;
    bit          prev_xfer = 1'b0;
    bit          err_exp = 1'b0;
    logic [31:0] last_x = '0;
    logic [31:0] last_y = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat();
`ifdef POLAR_ARB_STATS_EN
        return 32'(issued);
`else
        return 32'd0;
`endif
    endfunction

    task automatic rand_data();
        for (int i = 0; i < NREQ; i++) begin
            req_x[i*WIDTH +: WIDTH] = $urandom;
            req_y[i*WIDTH +: WIDTH] = $urandom;
        end
    endtask

    // One clock: check at the falling edge, advance the reference, return just after the rising edge.
    task automatic tick();
        int              k;
        int              j;
        bit              found;
        bit              front_rdy;
        logic [NREQ-1:0] exp_rdy;
        @(negedge clk);
        chk("cp_vld", 64'(cp_vld), 64'(prev_xfer));
        chk("cp_x", 64'(cp_x), 64'(last_x));
        chk("cp_y", 64'(cp_y), 64'(last_y));
        found = 1'b0;
        k = 0;
        for (int i = 0; i < NREQ; i++) begin
            j = (ptr + i) % NREQ;
            if (!found && req_vld[j]) begin
                found = 1'b1;
                k = j;
            end
        end
        exp_rdy = (found && q.size() < DEPTH) ? (NREQ'(1) << k) : '0;
        chk("req_rdy", 64'(req_rdy), 64'(exp_rdy));
        if (|(req_rdy & req_vld)) dut_xfers++;
        front_rdy = (q.size() > 0) && (q[0].t + LAT + 2 <= cyc);
        chk("res_vld", 64'(res_vld), 64'(front_rdy));
        if (front_rdy) begin
            chk("res_id", 64'(res_id), 64'(q[0].id));
            chk("res_mag", 64'(res_mag), 64'(q[0].mag));
            chk("res_phase", 64'(res_phase), 64'(q[0].ph));
        end
        chk("err", 64'(err), 64'(err_exp));
        chk("stat_issued", 64'(stat_issued), 64'(exp_stat()));
        if (front_rdy && res_rdy) void'(q.pop_front());
        prev_xfer = (exp_rdy != '0);
        if (prev_xfer) begin
            last_x = req_x[k*WIDTH +: WIDTH];
            last_y = req_y[k*WIDTH +: WIDTH];
            q.push_back('{k, mag_f(last_x, last_y), phase_f(last_x, last_y), cyc});
            ptr = (k + 1) % NREQ;
            issued++;
        end
        if (inject) err_exp = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        #1;
        chk("rst_cp_vld", 64'(cp_vld), 64'd0);
        chk("rst_cp_x", 64'(cp_x), 64'd0);
        chk("rst_cp_y", 64'(cp_y), 64'd0);
        chk("rst_res_vld", 64'(res_vld), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_stat", 64'(stat_issued), 64'd0);
        q.delete();
        ptr = 0;
        prev_xfer = 1'b0;
        err_exp = 1'b0;
        last_x = '0;
        last_y = '0;
        issued = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc++;
    endtask

    initial begin
        int n;
        do_reset();
        repeat (2) tick();

        // Single issue from requester 2.
        req_vld = 4'b0100;
        req_x[2*WIDTH +: WIDTH] = 32'd3;
        req_y[2*WIDTH +: WIDTH] = 32'd4;
        tick();
        req_vld = '0;
        n = 1;
        while (n < 40 && !res_vld) begin
            tick();
            n++;
        end
        chk("single_latency", 64'(n), 64'd19);
        chk("single_id", 64'(res_id), 64'd2);
        chk("single_mag", 64'(res_mag), 64'd7);
        chk("single_phase", 64'(res_phase), 64'(phase_f(32'd3, 32'd4)));
        chk("single_err", 64'(err), 64'd0);
        tick();

        // Fairness with every requester valid.
        do_reset();
        req_vld = '1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            #1;
            chk("fair_grant", 64'(req_rdy), 64'(NREQ'(1) << (i % NREQ)));
            tick();
        end

        // Backpressure until credits run out, then a single-cycle release.
        do_reset();
        res_rdy = 1'b0;
        dut_xfers = 0;
        repeat (60) begin
            rand_data();
            tick();
        end
        chk("bp_transfers", 64'(dut_xfers), 64'd32);
        chk("bp_rdy_zero", 64'(req_rdy), 64'd0);
        dut_xfers = 0;
        res_rdy = 1'b1;
        tick();
        res_rdy = 1'b0;
        repeat (5) tick();
        chk("bp_one_grant", 64'(dut_xfers), 64'd1);

        // Full FIFO with concurrent push and pop.
        res_rdy = 1'b1;
        repeat (60) begin
            rand_data();
            tick();
        end

        // Spurious pipeline result, then a mid-stream reset.
        req_vld = '0;
        repeat (40) tick();
        do_reset();
        inject = 1'b1;
        tick();
        inject = 1'b0;
        tick();
        chk("inject_err", 64'(err), 64'd1);
        chk("inject_fifo", 64'(res_vld), 64'd0);
        do_reset();
        req_vld = '1;
        repeat (12) begin
            rand_data();
            tick();
        end
        #2;
        do_reset();

        // Stats over 100 issues.
        req_vld = '1;
        repeat (100) begin
            rand_data();
            tick();
        end
        chk("stat_100", 64'(stat_issued), 64'(exp_stat()));
        req_vld = '0;
        repeat (25) tick();

        // Randomized traffic with stalls, then drain.
        do_reset();
        repeat (400) begin
            rand_data();
            req_vld = NREQ'($urandom);
            res_rdy = (cyc % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
        end
        req_vld = '0;
        res_rdy = 1'b1;
        repeat (60) tick();
        chk("drain_empty", 64'(res_vld), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/polar_arbiter.md
POLAR_ARBITER -- requirements
Module: polar_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 32: magnitude/coordinate width in bits.
REQ-002 SHALL have parameter NREQ, default 4: number of requesters, 2..16; IDW = clog2(NREQ).
REQ-003 SHALL have parameter LAT, default 17: fixed cycles from cp_vld to cp_res_vld in the shared polar pipeline.
REQ-004 SHALL have parameter DEPTH, default 32: result FIFO entries, power of two, DEPTH >= 2.
REQ-005 SHALL have ports: clk in 1, single clock, rising edge; rst in 1, reset is asynchronous and active-low.
REQ-006 SHALL have ports: req_vld in NREQ; req_rdy out NREQ; req_x in NREQ*WIDTH, signed, requester k at bits [k*WIDTH +: WIDTH]; req_y in NREQ*WIDTH, same packing.
REQ-007 SHALL have ports: cp_vld out 1; cp_x out WIDTH; cp_y out WIDTH: sample issued to the pipeline.
REQ-008 SHALL have ports: cp_res_vld in 1; cp_mag in WIDTH; cp_phase in 32: pipeline result.
REQ-009 SHALL have ports: res_vld out 1; res_rdy in 1; res_id out IDW; res_mag out WIDTH; res_phase out 32: routed result stream.
REQ-010 SHALL have ports: err out 1, sticky protocol error; stat_issued out 32, issued-sample count.

Function
REQ-011 Requester transfer SHALL occur when req_vld[k] and req_rdy[k] are both high at a clk edge.
REQ-012 req_rdy SHALL be one-hot or zero: high only for the granted index, and only when credit is available (REQ-016); it SHALL be combinational from req_vld, the RR pointer and the credit count.
REQ-013 Grant SHALL be round-robin: lowest index at or after the RR pointer, modulo NREQ, with req_vld high. After a transfer the pointer SHALL move to the granted index + 1, wrapping NREQ-1 to 0. Without a transfer the pointer SHALL hold.
REQ-014 On a transfer, cp_vld SHALL be 1 the next cycle, with cp_x/cp_y equal to the granted sample. Otherwise cp_vld SHALL be 0 and cp_x/cp_y SHALL hold.
REQ-015 A LAT-deep tag shift line SHALL carry {valid, id} aligned with cp_vld. When cp_res_vld is high, the tag emerging at that cycle SHALL be pushed with cp_mag/cp_phase into the result FIFO.
REQ-016 Outstanding count SHALL equal in-flight samples plus FIFO occupancy. Count +1 on issue, -1 on res_vld and res_rdy; simultaneous issue and pop SHALL leave it unchanged. Grant SHALL be allowed only when count < DEPTH, so the FIFO never overflows.
REQ-017 res_vld SHALL be high while the FIFO is non-empty. res_id/res_mag/res_phase SHALL show the head entry and SHALL stay stable while res_vld and !res_rdy. Results SHALL leave in issue order.
REQ-018 Push and pop on the same cycle SHALL both take effect. This includes the full case, where a pop frees the slot, and the empty-to-one case: the pushed entry appears the next cycle, with no bypass.
REQ-019 err SHALL set, and stay set until reset, if cp_res_vld is high with the emerging tag invalid, or if the emerging tag is valid with cp_res_vld low. The result FIFO SHALL NOT be written in either case.
REQ-020 Throughput SHALL be one issue per cycle when credits allow. Minimum latency from req transfer to res_vld SHALL be LAT+2 cycles.

Reset
REQ-021 rst low SHALL asynchronously clear: RR pointer to 0, cp_vld 0, cp_x/cp_y 0, all tag valids 0, FIFO pointers, outstanding count 0, res_vld 0, err 0, stat_issued 0.
REQ-022 Reset mid-operation SHALL discard in-flight and buffered results. The integration SHALL reset the pipeline on the same rst so that no stale cp_res_vld follows.

Configuration
REQ-023 With macro POLAR_ARB_STATS_EN defined, stat_issued SHALL increment on every issue and wrap from 2^32-1 to 0.
REQ-024 Without POLAR_ARB_STATS_EN, stat_issued SHALL be constant 0 and the counter SHALL not be built.

Verification
REQ-025 Single issue: req 2 valid, x=3, y=4, pipeline model LAT=17 -> cp_vld on cycle 1; res_vld on cycle 19 with res_id=2 and the model's mag/phase; err=0.
REQ-026 Fairness: all 4 req_vld held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; cp_vld high all 8 cycles.
REQ-027 Backpressure: res_rdy=0, all requesters continuously valid -> exactly 32 transfers, then req_rdy all 0. FIFO holds 32 entries. Set res_rdy=1 for 1 cycle -> exactly one new grant.
REQ-028 Simultaneous push/pop at full FIFO with res_rdy=1 -> occupancy holds at 32, order preserved, no loss.
REQ-029 Protocol error: inject cp_res_vld with no issue -> err=1 next cycle, FIFO unchanged. Assert rst low mid-stream -> all outputs at REQ-021 values immediately.
REQ-030 Stats: with POLAR_ARB_STATS_EN, 100 issues -> stat_issued=100. Without the macro, stat_issued=0.
